// File: rtl/seq_divider.sv
// seq_divider: signed restoring divider, one quotient bit per clock, with a start/busy/done handshake.
// Define SEQ_DIV_ZERO_DETECT_EN to make a zero divisor skip the iteration and raise div_by_zero.
module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Zlowout,
   output logic [WIDTH-1:0] Zhighout,
   output logic             div_by_zero
);
   typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [WIDTH-1:0] zlo_q, zlo_d, zhi_q, zhi_d, a_mag, b_mag;
   logic [WIDTH:0] shifted, trial;
   logic sq_q, sq_d, sr_q, sr_d, dbz_q, dbz_d, b_zero;
`ifdef SEQ_DIV_ZERO_DETECT_EN
   assign b_zero = (B == '0);
`else
   assign b_zero = 1'b0;
`endif
   // magnitudes are unsigned, so -2^(WIDTH-1) maps cleanly onto 2^(WIDTH-1)
   assign a_mag = A[WIDTH-1] ? -A : A;
   assign b_mag = B[WIDTH-1] ? -B : B;
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign trial = shifted - {1'b0, dvs_q};
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      sq_d = sq_q;
      sr_d = sr_q;
      zlo_d = zlo_q;
      zhi_d = zhi_q;
      dbz_d = dbz_q;
      unique case (state_q)
         CALC: begin
            rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_d = cnt_q + 1'b1;
            state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? SIGN : CALC;
         end
         SIGN: begin
            zlo_d = sq_q ? -quo_q : quo_q;
            zhi_d = sr_q ? -rem_q : rem_q;
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
            if (start) begin
               rem_d = '0;
               quo_d = a_mag;
               dvs_d = b_mag;
               sq_d = A[WIDTH-1] ^ B[WIDTH-1];
               sr_d = A[WIDTH-1];
               cnt_d = '0;
               dbz_d = b_zero;
               zlo_d = b_zero ? '1 : zlo_q;
               zhi_d = b_zero ? A : zhi_q;
               state_d = b_zero ? DONE : CALC;
            end
         end
      endcase
   end
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= IDLE;
         cnt_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         sq_q <= 1'b0;
         sr_q <= 1'b0;
         zlo_q <= '0;
         zhi_q <= '0;
         dbz_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         sq_q <= sq_d;
         sr_q <= sr_d;
         zlo_q <= zlo_d;
         zhi_q <= zhi_d;
         dbz_q <= dbz_d;
      end
   end
   assign busy = (state_q == CALC) || (state_q == SIGN);
   assign done = (state_q == DONE);
   assign Zlowout = zlo_q;
   assign Zhighout = zhi_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed scoreboard bench for seq_divider (quotient/remainder, handshake, reset, divide by zero).
module tb_seq_divider;
`ifdef SEQ_DIV_ZERO_DETECT_EN
   localparam bit ZD = 1'b1;
`else
   localparam bit ZD = 1'b0;
`endif
   logic clock, clear, start, busy, done, div_by_zero;
   logic [31:0] A, B, Zlowout, Zhighout, last_zlo, last_zhi;
   int n_cmp = 0, n_bad = 0;
   typedef struct {
      logic [31:0] zlo;
      logic [31:0] zhi;
      logic dbz;
      int lat;
      int bsy;
   } exp_t;
   exp_t sb[$];

   seq_divider dut (
      .clock(clock), .clear(clear), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .Zlowout(Zlowout), .Zhighout(Zhighout),
      .div_by_zero(div_by_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // reference: 64-bit signed division truncates toward zero, remainder follows dividend
   function automatic exp_t model(logic [31:0] a, logic [31:0] b);
      exp_t e;
      longint sa, sd, q, r;
      if (b == 32'd0) begin
         e.zlo = 32'hFFFF_FFFF;
         e.zhi = a;
         e.dbz = ZD;
         e.lat = ZD ? 1 : 34;
         e.bsy = ZD ? 0 : 33;
      end else begin
         sa = longint'($signed(a));
         sd = longint'($signed(b));
         q = sa / sd;
         r = sa % sd;
         e.zlo = q[31:0];
         e.zhi = r[31:0];
         e.dbz = 1'b0;
         e.lat = 34;
         e.bsy = 33;
      end
      return e;
   endfunction

   task automatic launch(logic [31:0] a, logic [31:0] b);
      A = a;
      B = b;
      start = 1'b1;
      sb.push_back(model(a, b));
   endtask

   task automatic wait_done(string tag, int inj);
      int lat = 0, bc = 0;
      bit seen = 0;
      exp_t e;
      while (!seen && lat < 100) begin
         @(negedge clock);
         lat++;
         if (lat == 1 || lat == inj + 1) start = 1'b0;
         if (lat == inj) begin
            start = 1'b1;
            A = 32'd9;
            B = 32'd3;
         end
         if (busy === 1'b1) bc++;
         seen = (done === 1'b1);
      end
      check($sformatf("%s_done_seen", tag), 64'(seen), 64'd1);
      check($sformatf("%s_sb_nonempty", tag), 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check($sformatf("%s_latency", tag), 64'(lat), 64'(e.lat));
         check($sformatf("%s_busy_cycles", tag), 64'(bc), 64'(e.bsy));
         check($sformatf("%s_Zlowout", tag), 64'(Zlowout), 64'(e.zlo));
         check($sformatf("%s_Zhighout", tag), 64'(Zhighout), 64'(e.zhi));
         check($sformatf("%s_div_by_zero", tag), 64'(div_by_zero), 64'(e.dbz));
         last_zlo = e.zlo;
         last_zhi = e.zhi;
      end
   endtask

   initial begin
      int dn;
      logic [31:0] ra, rb;
      clear = 1'b1;
      start = 1'b0;
      A = '0;
      B = '0;
      repeat (2) @(negedge clock);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_Zlowout", 64'(Zlowout), 64'd0);
      check("reset_Zhighout", 64'(Zhighout), 64'd0);
      check("reset_dbz", 64'(div_by_zero), 64'd0);
      clear = 1'b0;
      @(negedge clock);
      launch(32'd100, 32'd7);
      wait_done("pos_100_7", 0);
      @(negedge clock);
      check("pulse_done_low", 64'(done), 64'd0);
      check("pulse_busy_low", 64'(busy), 64'd0);
      launch(32'hFFFF_FF9C, 32'd7);
      wait_done("neg_dividend", 0);
      @(negedge clock);
      launch(32'd100, 32'hFFFF_FFF9);
      wait_done("neg_divisor", 0);
      @(negedge clock);
      launch(32'hFFFF_FF9C, 32'hFFFF_FFF9);
      wait_done("both_neg", 0);
      @(negedge clock);
      launch(32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("overflow", 0);
      @(negedge clock);
      launch(32'd100, 32'd7);
      wait_done("start_ignored", 6);
      repeat (5) @(negedge clock);
      check("hold_Zlowout", 64'(Zlowout), 64'(last_zlo));
      check("hold_Zhighout", 64'(Zhighout), 64'(last_zhi));
      launch(32'd1000, 32'd33);
      wait_done("b2b_first", 0);
      launch(32'd9, 32'd3);
      wait_done("b2b_second", 0);
      @(negedge clock);
      launch(32'd5, 32'd0);
      wait_done("div_zero", 0);
      @(negedge clock);
      launch(32'd7, 32'd2);
      wait_done("dbz_cleared", 0);
      @(negedge clock);
      launch(32'd1000, 32'd3);
      void'(sb.pop_back());
      @(negedge clock);
      start = 1'b0;
      repeat (10) @(negedge clock);
      check("abort_busy_before", 64'(busy), 64'd1);
      #2 clear = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_Zlowout", 64'(Zlowout), 64'd0);
      check("abort_Zhighout", 64'(Zhighout), 64'd0);
      @(negedge clock);
      clear = 1'b0;
      dn = 0;
      repeat (40) begin
         @(negedge clock);
         if (done === 1'b1) dn++;
      end
      check("abort_no_done", 64'(dn), 64'd0);
      launch(32'd50, 32'd5);
      wait_done("after_abort", 0);
      for (int i = 0; i < 4; i++) begin
         ra = $urandom;
         rb = $urandom >> (i * 7);
         if (rb == 32'd0) rb = 32'd1;
         if (i[0]) rb = -rb;
         @(negedge clock);
         launch(ra, rb);
         wait_done($sformatf("rand%0d", i), 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed 32-bit restoring divider that sits directly upstream of the ALU result registers.
- Produces the quotient/remainder pair the ALU presents on its Division path:
  - Zlowout = quotient.
  - Zhighout = remainder.
- Replaces a single-cycle combinational divide with an iterative datapath and a start/busy/done handshake, so the control unit stalls while a divide is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- clear  input  1  reset, asynchronous, active-high.
- start  input  1  request a divide; sampled only when busy=0.
- A  input  WIDTH  dividend, two's complement.
- B  input  WIDTH  divisor, two's complement.
- busy  output  1  high while a divide is in progress.
- done  output  1  one-cycle pulse; results valid from this cycle onward.
- Zlowout  output  WIDTH  quotient.
- Zhighout  output  WIDTH  remainder.
- div_by_zero  output  1  divisor-was-zero flag; see Optional Feature.

Behaviour:
- Reset: clear=1 forces the following immediately, regardless of clock:
  - state=IDLE, counter=0.
  - busy=0, done=0, div_by_zero=0.
  - Zlowout=0, Zhighout=0.
  - Internal accumulators are cleared.
  - A clear asserted mid-divide aborts it; no done pulse is produced for the aborted operation.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: latch |A| and |B| into the magnitude registers, record sign_q=A[msb]^B[msb] and sign_r=A[msb], set counter=0, go to CALC.
- CALC:
  - busy=1.
  - Each edge performs one restoring step:
    - Shift {rem,quo} left by 1.
    - Trial-subtract the divisor magnitude from rem.
    - If the trial result is non-negative, keep it and set the quotient LSB to 1; otherwise restore rem and set the quotient LSB to 0.
  - Counter increments each edge; after WIDTH steps, go to SIGN.
- SIGN:
  - busy=1.
  - On the edge: Zlowout = sign_q ? -quo : quo; Zhighout = sign_r ? -rem : rem.
  - Go to DONE.
- DONE:
  - busy=0, done=1 for exactly this cycle.
  - Next edge: go to CALC if start=1 (back-to-back divides allowed), else go to IDLE.
- Latency: done is high for the cycle after the (WIDTH+2)th rising edge following the edge that sampled start (34 edges at default).
- Output hold: Zlowout, Zhighout and div_by_zero hold their values until the next SIGN (or early-exit) update or until clear.
- start while busy=1 is ignored. Operands are latched once; changes to A/B during CALC have no effect.
- Arithmetic rules:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Invariant: A = Q*B + R, with |R| < |B|.
- Overflow: -2^(WIDTH-1) / -1 gives Zlowout=0x80000000, Zhighout=0. No flag is raised.
- Magnitude of -2^(WIDTH-1) is taken as the unsigned value 0x80000000. The datapath is WIDTH+1 bits wide internally to avoid loss.

Optional Feature:
- Macro: SEQ_DIV_ZERO_DETECT_EN.
- Defined:
  - When start is sampled with B==0, the FSM goes IDLE->DONE directly.
  - done is high in the cycle after that edge (latency 1 edge).
  - Results: Zlowout=0xFFFFFFFF, Zhighout=A (unmodified), div_by_zero=1.
  - div_by_zero clears on the next accepted start whose B is non-zero.
- Undefined:
  - No zero check; the full WIDTH+2 edge sequence runs.
  - div_by_zero is tied to 0.
  - Result follows the algorithm: for A>=0, Zlowout=0xFFFFFFFF and Zhighout=A. For A<0 the result is deterministic but not checked.

Test Plan:
- Positive divide: A=100, B=7, start for 1 cycle -> busy high for 33 cycles, done after 34 edges; Zlowout=0x0000000E, Zhighout=0x00000002.
- Signed divide: A=-100 (0xFFFFFF9C), B=7 -> Zlowout=0xFFFFFFF2 (-14), Zhighout=0xFFFFFFFE (-2). A=100, B=-7 -> Zlowout=0xFFFFFFF2, Zhighout=0x00000002.
- Overflow corner: A=0x80000000, B=0xFFFFFFFF -> Zlowout=0x80000000, Zhighout=0, div_by_zero=0.
- Handshake: assert start again at cycle 5 of CALC with A=9, B=3 -> ignored, first result unchanged. Assert start in the DONE cycle with A=9, B=3 -> second done 34 edges later with Zlowout=3, Zhighout=0.
- Reset mid-operation: clear=1 at cycle 10 of CALC -> busy, done and outputs go to 0 immediately. No done pulse appears afterwards; a subsequent 50/5 divide returns Zlowout=10, Zhighout=0.
- Divide by zero: A=5, B=0.
  - With SEQ_DIV_ZERO_DETECT_EN: done after 1 edge, Zlowout=0xFFFFFFFF, Zhighout=5, div_by_zero=1.
  - Without: done after 34 edges, same Zlowout/Zhighout, div_by_zero=0.
